logic_gate_checker: RTL and testbench

LOGIC_GATE_CHECKER -- requirements
Module: logic_gate_checker

---
 rtl/gate_check_pkg.sv | 23 ++
 rtl/gate_ref_model.sv | 24 ++
 rtl/logic_gate_checker.sv | 106 ++++++++++
 tb/tb_logic_gate_checker.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/gate_check_pkg.sv
// Shared encodings for gate checkers: op_sel values, FSM states and op legality.
package gate_check_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_NAND = 3'd2;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return (op <= OP_XNOR);
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model of a two-input gate; reserved ops yield 0.
module gate_ref_model
  import gate_check_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic            a,
  input  logic            b,
  output logic            exp_y
);

  always_comb begin
    exp_y = 1'b0;
    case (op)
      OP_AND:  exp_y = a & b;
      OP_OR:   exp_y = a | b;
      OP_NAND: exp_y = ~(a & b);
      OP_NOR:  exp_y = ~(a | b);
      OP_XOR:  exp_y = a ^ b;
      OP_XNOR: exp_y = ~(a ^ b);
      default: exp_y = 1'b0;
    endcase
  end

endmodule

// File: rtl/logic_gate_checker.sv
// Checks a gate's observed output against a reference over NUM_SAMPLES samples,
// tracking mismatches, input-combination coverage and the first failing sample.
module logic_gate_checker
  import gate_check_pkg::*;
#(
  parameter int unsigned NUM_SAMPLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op_sel,
  input  logic             sample_valid,
  input  logic             a,
  input  logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             op_err,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       cov,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [1:0]       first_err_ab
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q;
  logic            exp_y;
  logic            start_ok;
  logic            accept;
  logic            last_sample;

  gate_ref_model u_ref (
    .op    (op_q),
    .a     (a),
    .b     (b),
    .exp_y (exp_y)
  );

  // start is only honoured outside RUN; samples only inside it
  assign start_ok    = start && (state_q != ST_RUN);
  assign accept      = (state_q == ST_RUN) && sample_valid;
  assign last_sample = (sample_count == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = op_is_legal(op_sel) ? ST_RUN : ST_DONE;
      ST_RUN:           if (accept && last_sample) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Run results; cleared by an honoured start, updated by accepted samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q          <= OP_AND;
      op_err        <= 1'b0;
      sample_count  <= '0;
      err_count     <= '0;
      cov           <= '0;
      first_err_idx <= '0;
      first_err_ab  <= '0;
    end else if (start_ok) begin
      op_q          <= op_sel;
      op_err        <= ~op_is_legal(op_sel);
      sample_count  <= '0;
      err_count     <= '0;
      cov           <= '0;
      first_err_idx <= '0;
      first_err_ab  <= '0;
    end else if (accept) begin
      sample_count   <= sample_count + CNT_W'(1);
      cov[{a, b}]    <= 1'b1;
      if (y != exp_y) begin
        if (err_count != '1) err_count <= err_count + CNT_W'(1);
        if (err_count == '0) begin
          first_err_idx <= sample_count;
          first_err_ab  <= {a, b};
        end
      end
    end
  end

  assign pass = done & ~op_err & (err_count == '0) & (cov == 4'b1111);

endmodule

// File: tb/tb_logic_gate_checker.sv
// Directed-vector bench for logic_gate_checker with hand-computed expectations.
module tb_logic_gate_checker;

  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [2:0]       op_sel;
  logic             sample_valid;
  logic             a, b, y;
  logic             busy, done, pass, op_err;
  logic [CNT_W-1:0] sample_count, err_count, first_err_idx;
  logic [3:0]       cov;
  logic [1:0]       first_err_ab;

  int total = 0;
  int bad   = 0;

  logic_gate_checker #(.NUM_SAMPLES(4), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .op_sel        (op_sel),
    .sample_valid  (sample_valid),
    .a             (a),
    .b             (b),
    .y             (y),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .op_err        (op_err),
    .sample_count  (sample_count),
    .err_count     (err_count),
    .cov           (cov),
    .first_err_idx (first_err_idx),
    .first_err_ab  (first_err_ab)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [2:0] op);
    start  = 1'b1;
    op_sel = op;
    cycle();
    start  = 1'b0;
  endtask

  task automatic send(input logic sa, input logic sb, input logic sy);
    sample_valid = 1'b1;
    a = sa; b = sb; y = sy;
    cycle();
    sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op_sel = 3'd0; sample_valid = 1'b0;
    a = 1'b0; b = 1'b0; y = 1'b0;
    #3;
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_pass",  32'(pass), 32'd0);
    chk("rst_cnt",   32'(sample_count), 32'd0);
    rst_n = 1'b1;
    cycle();

    // Scenario 1: AND, all correct
    do_start(3'd0);
    chk("s1_busy", 32'(busy), 32'd1);
    send(0, 0, 0); send(0, 1, 0); send(1, 0, 0);
    chk("s1_not_done", 32'(done), 32'd0);
    chk("s1_cnt3",     32'(sample_count), 32'd3);
    send(1, 1, 1);
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_busy_lo", 32'(busy), 32'd0);
    chk("s1_pass", 32'(pass), 32'd1);
    chk("s1_err",  32'(err_count), 32'd0);
    chk("s1_cov",  32'(cov), 32'hf);
    chk("s1_cnt",  32'(sample_count), 32'd4);

    // Scenario 2: XOR with a mismatch on the 3rd sample; then sample_valid in DONE ignored
    do_start(3'd4);
    send(0, 0, 0); send(0, 1, 1); send(1, 0, 0); send(1, 1, 0);
    chk("s2_done", 32'(done), 32'd1);
    chk("s2_err",  32'(err_count), 32'd1);
    chk("s2_fidx", 32'(first_err_idx), 32'd2);
    chk("s2_fab",  32'(first_err_ab), 32'd2);
    chk("s2_pass", 32'(pass), 32'd0);
    send(0, 0, 1);
    idle(2);
    chk("s2_hold_cnt", 32'(sample_count), 32'd4);
    chk("s2_hold_err", 32'(err_count), 32'd1);
    chk("s2_hold_done", 32'(done), 32'd1);

    // Scenario 3: NAND, correct but incomplete coverage
    do_start(3'd2);
    chk("s3_clear_err", 32'(err_count), 32'd0);
    send(0, 0, 1); send(0, 0, 1); send(1, 1, 0); send(1, 1, 0);
    chk("s3_cov",  32'(cov), 32'h9);
    chk("s3_err",  32'(err_count), 32'd0);
    chk("s3_done", 32'(done), 32'd1);
    chk("s3_pass", 32'(pass), 32'd0);

    // Scenario 4: reserved op goes straight to DONE with op_err
    do_start(3'd6);
    chk("s4_done",  32'(done), 32'd1);
    chk("s4_operr", 32'(op_err), 32'd1);
    chk("s4_pass",  32'(pass), 32'd0);
    chk("s4_cnt",   32'(sample_count), 32'd0);
    chk("s4_busy",  32'(busy), 32'd0);

    // Scenario 5: async reset mid-run, then a fresh passing run
    do_start(3'd3);
    chk("s5_operr_clr", 32'(op_err), 32'd0);
    send(0, 0, 1); send(0, 1, 0);
    chk("s5_cnt2", 32'(sample_count), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("s5_rst_busy", 32'(busy), 32'd0);
    chk("s5_rst_cnt",  32'(sample_count), 32'd0);
    chk("s5_rst_cov",  32'(cov), 32'd0);
    #1;
    rst_n = 1'b1;
    do_start(3'd3);
    chk("s5_busy", 32'(busy), 32'd1);
    send(0, 0, 1); send(0, 1, 0); send(1, 0, 0); send(1, 1, 0);
    chk("s5_pass", 32'(pass), 32'd1);

    // Scenario 6: OR; start in RUN ignored (XOR would flag 11/1), gapped samples
    do_start(3'd1);
    send(0, 0, 0);
    do_start(3'd4);
    chk("s6_cnt_kept", 32'(sample_count), 32'd1);
    idle(3);
    send(1, 1, 1); send(0, 1, 1);
    chk("s6_busy", 32'(busy), 32'd1);
    send(1, 0, 1);
    chk("s6_cnt",  32'(sample_count), 32'd4);
    chk("s6_done", 32'(done), 32'd1);
    chk("s6_err",  32'(err_count), 32'd0);
    chk("s6_pass", 32'(pass), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
